sram_line_fetcher: RTL and testbench
====================================

Name: sram_line_fetcher

Overview:
- Sits directly upstream of sram_controller. At the start of each display line it issues sequential 16-bit read requests for one line of pixel data.
- Returned words are collected into a ping-pong line buffer.
- The VGA draw engine reads the completed bank while the next line is fetched into the other bank.
- Decouples fixed-rate pixel output from the variable-latency SRAM read path.

Parameters:
- ADDR_W, 20, SRAM word address width.
- WORDS_PER_LINE, 40, 16-bit words per display line (640 px at 1 bpp).
- NUM_LINES, 480, number of valid display lines.
- BASE_ADDR, 20'h00000, SRAM word address of line 0.

Ports:
- Clk  in  1  system clock, all logic on posedge.
- Reset  in  1  asynchronous, active-high reset.
- line_start  in  1  one-cycle pulse: begin fetching line line_num.
- line_num  in  9  line index to fetch, sampled when line_start=1.
- mem_req  out  1  read request to sram_controller.
- mem_addr  out  ADDR_W  word address of the current request.
- mem_ack  in  1  one-cycle pulse: mem_rdata valid, request consumed.
- mem_rdata  in  16  read data from sram_controller.
- rd_idx  in  6  word index into the display bank (0..WORDS_PER_LINE-1).
- rd_data  out  16  registered word from the display bank.
- busy  out  1  fetch in progress.
- line_done  out  1  one-cycle pulse: all words of the line written.
- overrun  out  1  sticky: a line was aborted before completion.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Reset values (asynchronous, Reset=1): state=IDLE, mem_req=0, mem_addr=0, busy=0, line_done=0, overrun=0, rd_data=0, wr_bank=0, word_cnt=0. Buffer RAM contents are not reset.
- Bank selection: fetch writes bank wr_bank; display reads bank ~wr_bank. wr_bank toggles on every accepted line_start.
- Accepted line_start: line_start=1 with line_num < NUM_LINES. If line_num >= NUM_LINES, the pulse is ignored entirely: no toggle, no fetch, no overrun.
- Start address: BASE_ADDR + line_num*WORDS_PER_LINE, computed at full width and truncated to ADDR_W.
- States:
  - IDLE: mem_req=0, busy=0. On an accepted line_start: latch the start address into mem_addr, word_cnt=0, go to FETCH.
  - FETCH: mem_req=1, busy=1. mem_addr is held stable until mem_ack.
    - On mem_ack: write mem_rdata to buf[wr_bank][word_cnt].
    - If word_cnt==WORDS_PER_LINE-1, go to DONE with mem_req=0 next cycle.
    - Otherwise word_cnt+1, mem_addr+1 (wraps modulo 2^ADDR_W), mem_req stays 1.
  - DONE: line_done=1 for exactly this cycle, busy=0, then IDLE.
- Handshake rules:
  - At most one outstanding request.
  - mem_ack outside FETCH is ignored.
  - mem_addr changes only on the cycle after mem_ack or on a restart.
- Overrun: accepted line_start while in FETCH:
  - overrun<=1, wr_bank toggles, and the current line is aborted with no line_done.
  - word_cnt=0 and mem_addr is loaded with the new start address; stay in FETCH.
  - A mem_ack in the same cycle is discarded and its data is not written.
- Accepted line_start while in DONE: line_done still pulses, and the next state is FETCH for the new line.
- clr_overrun clears overrun; if set and clear occur in the same cycle, set wins.
- Read port: rd_data <= buf[~wr_bank][rd_idx], 1-cycle latency. rd_idx >= WORDS_PER_LINE returns 16'h0000.
- Reset asserted mid-fetch: mem_req drops asynchronously. Partial data is left in place but is never presented as complete.

Test Plan:
- Basic line fetch: reset, pulse line_start with line_num=3, mem_ack 2 cycles after each request, mem_rdata=16'hA000+idx -> addresses 120..159 in order, one line_done, busy low after. Then pulse line_start with line_num=4; rd_idx=5 -> rd_data=16'hA005 one cycle later.
- Ping-pong isolation: fetch line 0 (data 16'h1111), then line 1 (data 16'h2222) while holding rd_idx=0 -> rd_data=16'h1111 throughout the line 1 fetch; after the next line_start it reads 16'h2222.
- Overrun: line_start line 10, ack only 7 words, then line_start line 11 coincident with an ack -> overrun=1, no line_done for line 10, next mem_addr=440. The discarded word is not in the buffer. clr_overrun together with a new overrun -> overrun stays 1.
- Boundaries:
  - line_num=480 -> no mem_req, wr_bank unchanged.
  - line_num=479 -> last address 19199.
  - BASE_ADDR=20'hFFFF0, line 0 -> addresses wrap FFFF0..FFFFF, 00000..00017.
- Reset mid-fetch: assert Reset after 20 acks -> mem_req=0, busy=0 and overrun=0 immediately. After release, line_start line 2 fetches from address 80.
- Spurious ack: mem_ack pulses in IDLE and DONE -> no buffer write, no state change.

Source files
------------

// File: rtl/sram_line_fetcher.sv
// -----------------------------------------------------------------------------
// sram_line_fetcher
//
// Purpose:
//   Fetches one display line of 16-bit words from the SRAM controller into a
//   ping-pong line buffer. The VGA draw engine reads the completed bank while
//   the next line is fetched into the other bank. This decouples the
//   fixed-rate pixel output from the variable-latency SRAM read path.
//
// Ports:
//   Clk          in   system clock, all logic on posedge
//   Reset        in   asynchronous, active-high reset
//   line_start   in   one-cycle pulse: begin fetching line line_num
//   line_num     in   [8:0] line index, sampled when line_start=1
//   mem_req      out  read request to sram_controller
//   mem_addr     out  [ADDR_W-1:0] word address of the current request
//   mem_ack      in   one-cycle pulse: mem_rdata valid, request consumed
//   mem_rdata    in   [15:0] read data from sram_controller
//   rd_idx       in   [5:0] word index into the display bank
//   rd_data      out  [15:0] registered word from the display bank
//   busy         out  fetch in progress
//   line_done    out  one-cycle pulse: all words of the line written
//   overrun      out  sticky: a line was aborted before completion
//   clr_overrun  in   clears overrun (a simultaneous set wins)
//   state_dbg    out  [1:0] current FSM state (0=IDLE, 1=FETCH, 2=DONE)
//
// Memory handshake (valid/ready semantics):
//   mem_req acts as "valid" for the request held on mem_addr; mem_ack is the
//   single-cycle "ready + data" response. A request is consumed only on the
//   cycle where mem_req=1 and mem_ack=1. mem_addr is stable while mem_req=1
//   and changes only on the cycle after an ack or on a restart, so at most
//   one request is ever outstanding. mem_ack while mem_req=0 is ignored.
// -----------------------------------------------------------------------------
module sram_line_fetcher #(
  parameter int                ADDR_W         = 20,
  parameter int                WORDS_PER_LINE = 40,
  parameter int                NUM_LINES      = 480,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              line_start,
  input  logic [8:0]        line_num,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  input  logic [5:0]        rd_idx,
  output logic [15:0]       rd_data,
  output logic              busy,
  output logic              line_done,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic [1:0]        state_dbg
);

  // Word counter width follows the read index port, which bounds the line
  // length at 64 words.
  localparam int         CNT_W    = 6;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       rd_data_q;

  // Line buffer banks; contents are intentionally not reset.
  logic [15:0]       bank0_mem [WORDS_PER_LINE];
  logic [15:0]       bank1_mem [WORDS_PER_LINE];

  // ---------------------------------------------------------------------------
  // Line-start qualification and start address
  // ---------------------------------------------------------------------------
  logic              line_ok;
  logic              accept;
  logic [ADDR_W-1:0] start_addr;
  logic              wr_en;

  // Out-of-range line numbers are dropped with no side effects at all.
  assign line_ok = ({23'd0, line_num} < 32'(NUM_LINES));
  assign accept  = line_start && line_ok;

  // Arithmetic modulo 2^ADDR_W gives the same result as computing at full
  // width and truncating, so the sum is formed directly at ADDR_W bits.
  assign start_addr = BASE_ADDR
                    + (ADDR_W'(line_num) * ADDR_W'(WORDS_PER_LINE));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      word_cnt_q <= '0;
      wr_bank_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      word_cnt_q <= word_cnt_d;
      wr_bank_q  <= wr_bank_d;
      overrun_q  <= overrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    word_cnt_d = word_cnt_q;
    overrun_d  = overrun_q;
    wr_en      = 1'b0;

    // Every accepted line start flips the banks, whatever the state.
    wr_bank_d  = wr_bank_q ^ accept;

    // Sticky overrun: a restart during FETCH sets it, and a set in the same
    // cycle as a clear takes priority.
    if (accept && (state_q == ST_FETCH)) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mem_addr_d = start_addr;
          word_cnt_d = '0;
          state_d    = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (accept) begin
          // Abort the current line. Any ack in this cycle belongs to the
          // aborted line and its data is dropped.
          mem_addr_d = start_addr;
          word_cnt_d = '0;
        end else if (mem_ack) begin
          wr_en = 1'b1;
          if (word_cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
            mem_addr_d = mem_addr_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        // line_done still pulses here; a new line may start immediately.
        if (accept) begin
          mem_addr_d = start_addr;
          word_cnt_d = '0;
          state_d    = ST_FETCH;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Line buffer write port (fetch side, bank wr_bank)
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      if (wr_bank_q) begin
        bank1_mem[word_cnt_q] <= mem_rdata;
      end else begin
        bank0_mem[word_cnt_q] <= mem_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffer read port (display side, bank ~wr_bank)
  // ---------------------------------------------------------------------------
  logic        rd_in_range;
  logic [15:0] rd_word;

  assign rd_in_range = ({26'd0, rd_idx} < 32'(WORDS_PER_LINE));

  always_comb begin
    rd_word = 16'h0000;
    if (rd_in_range) begin
      rd_word = wr_bank_q ? bank0_mem[rd_idx] : bank1_mem[rd_idx];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_data_q <= 16'h0000;
    end else begin
      rd_data_q <= rd_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Status flags decode straight from the state register so that an
  // asynchronous reset drops mem_req and busy immediately.
  // ---------------------------------------------------------------------------
  assign mem_req   = (state_q == ST_FETCH);
  assign busy      = (state_q == ST_FETCH);
  assign line_done = (state_q == ST_DONE);
  assign mem_addr  = mem_addr_q;
  assign overrun   = overrun_q;
  assign rd_data   = rd_data_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sram_line_fetcher.sv
// -----------------------------------------------------------------------------
// tb_sram_line_fetcher
//
// Bench for sram_line_fetcher. Two instances: u_dut uses the default base
// address, u_dut_wrap uses BASE_ADDR=20'hFFFF0 to exercise address wrap.
// Expected SRAM addresses are queued when a line start is driven and popped
// when the DUT presents each request. A small model of both buffer banks
// predicts rd_data.
// -----------------------------------------------------------------------------
module tb_sram_line_fetcher;

  localparam int WPL = 40;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic        line_start  = 1'b0;
  logic [8:0]  line_num    = '0;
  logic        mem_ack     = 1'b0;
  logic [15:0] mem_rdata   = '0;
  logic [5:0]  rd_idx      = '0;
  logic        clr_overrun = 1'b0;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        line_done;
  logic        overrun;
  logic [1:0]  state_dbg;

  logic        line_start2  = 1'b0;
  logic [8:0]  line_num2    = '0;
  logic        mem_ack2     = 1'b0;
  logic [15:0] mem_rdata2   = '0;
  logic [5:0]  rd_idx2      = '0;
  logic        clr_overrun2 = 1'b0;
  logic        mem_req2;
  logic [19:0] mem_addr2;
  logic [15:0] rd_data2;
  logic        busy2;
  logic        line_done2;
  logic        overrun2;
  logic [1:0]  state_dbg2;

  sram_line_fetcher u_dut (
    .Clk(Clk), .Reset(Reset), .line_start(line_start), .line_num(line_num),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy),
    .line_done(line_done), .overrun(overrun), .clr_overrun(clr_overrun),
    .state_dbg(state_dbg)
  );

  sram_line_fetcher #(.BASE_ADDR(20'hFFFF0)) u_dut_wrap (
    .Clk(Clk), .Reset(Reset), .line_start(line_start2), .line_num(line_num2),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2),
    .mem_rdata(mem_rdata2), .rd_idx(rd_idx2), .rd_data(rd_data2),
    .busy(busy2), .line_done(line_done2), .overrun(overrun2),
    .clr_overrun(clr_overrun2), .state_dbg(state_dbg2)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and buffer model
  // ---------------------------------------------------------------------------
  logic [19:0] exp_q[$];
  logic [19:0] exp2_q[$];
  logic [15:0] mdl_mem [2][WPL];
  bit          mdl_vld [2][WPL];
  bit          mdl_bank = 1'b0;
  int          cur_cnt  = 0;
  int          n_vec    = 0;
  int          n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  function automatic logic [15:0] mdl_read(input int idx);
    if (idx >= WPL) return 16'h0000;
    return mdl_mem[mdl_bank ^ 1'b1][idx];
  endfunction

  function automatic bit mdl_known(input int idx);
    if (idx >= WPL) return 1'b1;
    return mdl_vld[mdl_bank ^ 1'b1][idx];
  endfunction

  task automatic check_rd_hold(input string name);
    if (mdl_known(int'(rd_idx))) chk(name, rd_data, mdl_read(int'(rd_idx)));
  endtask

  // Model side of an accepted line start: flip banks, queue all addresses.
  task automatic accept_line(input int ln);
    mdl_bank = mdl_bank ^ 1'b1;
    exp_q.delete();
    for (int i = 0; i < WPL; i++) exp_q.push_back(20'(ln * WPL + i));
    cur_cnt = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left on a negedge)
  // ---------------------------------------------------------------------------
  task automatic start_line(input int ln);
    line_start = 1'b1;
    line_num   = 9'(ln);
    if (ln < 480) accept_line(ln);
    tick();
    line_start = 1'b0;
  endtask

  task automatic ack_words(input int n, input logic [15:0] dbase,
                           input bit inc, input int lat);
    for (int i = 0; i < n; i++) begin
      repeat (lat) tick();
      chk("mem_req", mem_req, 1);
      chk("busy", busy, 1);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL addr_queue: request with no expected address");
      end else begin
        chk("mem_addr", mem_addr, exp_q.pop_front());
      end
      check_rd_hold("rd_hold");
      mem_ack   = 1'b1;
      mem_rdata = dbase + (inc ? 16'(cur_cnt) : 16'd0);
      mdl_mem[mdl_bank][cur_cnt] = mem_rdata;
      mdl_vld[mdl_bank][cur_cnt] = 1'b1;
      cur_cnt++;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
    end
  endtask

  // Called in the DONE cycle; optionally throws a spurious ack at it.
  task automatic finish_line(input bit spurious);
    chk("line_done", line_done, 1);
    chk("done_busy", busy, 0);
    chk("done_req", mem_req, 0);
    if (spurious) begin
      mem_ack   = 1'b1;
      mem_rdata = 16'hBAD1;
    end
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    chk("line_done_clr", line_done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_state", state_dbg, 0);
  endtask

  task automatic check_rd(input int idx, input string name);
    rd_idx = 6'(idx);
    tick();
    if (mdl_known(idx)) chk(name, rd_data, mdl_read(idx));
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    int          ln;
    logic [15:0] dbase;
    bit          inc;
    int          lat;
    int          rd_i;
    bit          chk_en;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Each row is fetched in full; exp_rd is the previous row's word at rd_i.
    tbl[0] = '{ln: 3,   dbase: 16'hA000, inc: 1, lat: 2, rd_i: 0,  chk_en: 0, exp_rd: 16'h0000};
    tbl[1] = '{ln: 4,   dbase: 16'hB000, inc: 1, lat: 1, rd_i: 5,  chk_en: 1, exp_rd: 16'hA005};
    tbl[2] = '{ln: 0,   dbase: 16'h1111, inc: 0, lat: 1, rd_i: 39, chk_en: 1, exp_rd: 16'hB027};
    tbl[3] = '{ln: 1,   dbase: 16'h2222, inc: 0, lat: 2, rd_i: 0,  chk_en: 1, exp_rd: 16'h1111};
    tbl[4] = '{ln: 2,   dbase: 16'h3333, inc: 1, lat: 1, rd_i: 0,  chk_en: 1, exp_rd: 16'h2222};
    tbl[5] = '{ln: 479, dbase: 16'hC000, inc: 1, lat: 1, rd_i: 40, chk_en: 1, exp_rd: 16'h0000};
    tbl[6] = '{ln: 5,   dbase: 16'hD000, inc: 1, lat: 1, rd_i: 63, chk_en: 1, exp_rd: 16'h0000};
    tbl[7] = '{ln: 6,   dbase: 16'h5A00, inc: 1, lat: 3, rd_i: 10, chk_en: 1, exp_rd: 16'hD00A};

    // ---- reset state ----
    repeat (3) tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_state", state_dbg, 0);
    Reset = 1'b0;
    tick();

    // ---- address wrap on the second instance ----
    line_start2 = 1'b1;
    line_num2   = 9'd0;
    for (int i = 0; i < WPL; i++) exp2_q.push_back(20'hFFFF0 + 20'(i));
    tick();
    line_start2 = 1'b0;
    for (int i = 0; i < WPL; i++) begin
      chk("wrap_req", mem_req2, 1);
      chk("wrap_addr", mem_addr2, exp2_q.pop_front());
      mem_ack2   = 1'b1;
      mem_rdata2 = 16'(i);
      tick();
      mem_ack2   = 1'b0;
    end
    chk("wrap_line_done", line_done2, 1);
    tick();
    chk("wrap_idle", mem_req2, 0);

    // ---- table-driven full line fetches ----
    for (int r = 0; r < 8; r++) begin
      rd_idx = 6'(tbl[r].rd_i);
      start_line(tbl[r].ln);
      ack_words(WPL, tbl[r].dbase, tbl[r].inc, tbl[r].lat);
      finish_line(1'b0);
      if (tbl[r].chk_en) chk("table_rd", rd_data, tbl[r].exp_rd);
    end

    // ---- line_num out of range: ignored entirely ----
    rd_idx = 6'd3;
    start_line(480);
    chk("oor_req", mem_req, 0);
    chk("oor_busy", busy, 0);
    chk("oor_state", state_dbg, 0);
    tick();
    chk("oor_bank", rd_data, mdl_read(3));

    // ---- spurious ack in IDLE ----
    mem_ack   = 1'b1;
    mem_rdata = 16'hBAD0;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    chk("spur_idle_req", mem_req, 0);
    chk("spur_idle_state", state_dbg, 0);
    chk("spur_idle_done", line_done, 0);

    // ---- overrun with a coincident ack ----
    rd_idx = 6'd39;                   // exposes any IDLE spurious write
    start_line(10);
    ack_words(7, 16'hE000, 1'b1, 1);
    rd_idx     = 6'd7;
    line_start = 1'b1;
    line_num   = 9'd11;
    mem_ack    = 1'b1;
    mem_rdata  = 16'hDEAD;             // must be discarded
    accept_line(11);
    tick();
    line_start = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    chk("ovr_set", overrun, 1);
    chk("ovr_no_done", line_done, 0);
    chk("ovr_state", state_dbg, 1);
    ack_words(WPL, 16'hF000, 1'b1, 1);
    finish_line(1'b1);                 // spurious ack in DONE
    check_rd(6, "ovr_partial_rd6");
    check_rd(7, "ovr_discard_rd7");

    // ---- set and clear of overrun together: set wins ----
    rd_idx = 6'd39;                   // exposes any DONE spurious write
    start_line(12);
    ack_words(3, 16'h7100, 1'b1, 1);
    line_start  = 1'b1;
    line_num    = 9'd13;
    clr_overrun = 1'b1;
    accept_line(13);
    tick();
    line_start  = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    tick();
    clr_overrun = 1'b0;
    chk("ovr_cleared", overrun, 0);
    ack_words(WPL, 16'h7700, 1'b1, 1);
    finish_line(1'b0);

    // ---- reset in the middle of a fetch ----
    start_line(20);
    ack_words(5, 16'h4000, 1'b1, 1);
    line_start = 1'b1;
    line_num   = 9'd21;
    accept_line(21);
    tick();
    line_start = 1'b0;
    ack_words(20, 16'h4400, 1'b1, 1);
    chk("pre_rst_overrun", overrun, 1);
    Reset = 1'b1;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_rd", rd_data, 0);
    mdl_bank = 1'b0;
    exp_q.delete();
    tick();
    Reset = 1'b0;
    tick();
    start_line(2);
    ack_words(WPL, 16'h6600, 1'b1, 1);
    finish_line(1'b0);
    rd_idx = 6'd9;
    start_line(7);
    ack_words(2, 16'h8800, 1'b1, 1);
    chk("post_rst_rd", rd_data, 16'h6609);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
